// File: rtl/qspi_cmd_arb.sv
// qspi_cmd_arb: N-channel command arbiter/register for the QSPI controller.
// Picks one requester (fixed or round-robin), latches its command, offers it
// to the phase sequencer over valid/ready and holds it until done or timeout.
module qspi_cmd_arb #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 0
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        io_req_valid,
  output logic [NUM_CH-1:0]        io_req_ready,
  input  logic [8*NUM_CH-1:0]      io_req_inst,
  input  logic [ADDR_W*NUM_CH-1:0] io_req_addr,
  input  logic [4*NUM_CH-1:0]      io_req_flags,
  input  logic [4*NUM_CH-1:0]      io_req_size,
  input  logic [8*NUM_CH-1:0]      io_req_burstlen,
  input  logic                     io_addr4b,
  output logic                     io_cmd_valid,
  input  logic                     io_cmd_ready,
  input  logic                     io_cmd_done,
  output logic [2:0]               io_cmd_ch,
  output logic [7:0]               io_inst,
  output logic [ADDR_W-1:0]        io_addr,
  output logic                     io_addr_valid,
  output logic                     io_dummy_valid,
  output logic                     io_wr_valid,
  output logic                     io_rd_valid,
  output logic [3:0]               io_inst_size,
  output logic [3:0]               io_addr_size,
  output logic [3:0]               io_dummy_size,
  output logic [3:0]               io_data_size,
  output logic [7:0]               io_data_burstlen,
  output logic                     io_busy,
  output logic                     io_err,
  output logic                     io_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_ptr;
  logic [15:0]       r_cnt;
  logic              r_err;
  logic [2:0]        r_ch;
  logic [7:0]        r_inst;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_flags;
  logic [3:0]        r_asz;
  logic [3:0]        r_size;
  logic [7:0]        r_bl;

  logic [7:0]        w_vld8;
  logic              w_found;
  logic [2:0]        w_gnt;
  logic [3:0]        w_j;
  logic [7:0]        w_inst;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_addr_m;
  logic [3:0]        w_flags;
  logic [3:0]        w_size;
  logic [7:0]        w_bl;
  logic [3:0]        w_asz;
  logic              w_acc;
  logic              w_illegal;
  logic              w_to;
  logic [2:0]        w_ptr_nxt;

  // Winner search: scan NUM_CH slots starting at 0 (fixed) or at the RR pointer.
  always_comb begin
    w_vld8  = 8'(io_req_valid);
    w_found = 1'b0;
    w_gnt   = '0;
    w_j     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (PRIO_MODE != 0) begin
        w_j = {1'b0, r_ptr} + 4'(k);
        if (w_j >= 4'(NUM_CH)) w_j = w_j - 4'(NUM_CH);
      end else begin
        w_j = 4'(k);
      end
      if (!w_found && w_vld8[w_j[2:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_j[2:0];
      end
    end
  end

  // Select the winner's fields; upper address bits vanish in 3-byte mode.
  always_comb begin
    w_inst  = '0;
    w_addr  = '0;
    w_flags = '0;
    w_size  = '0;
    w_bl    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_gnt == 3'(k)) begin
        w_inst  = io_req_inst[8*k +: 8];
        w_addr  = io_req_addr[ADDR_W*k +: ADDR_W];
        w_flags = io_req_flags[4*k +: 4];
        w_size  = io_req_size[4*k +: 4];
        w_bl    = io_req_burstlen[8*k +: 8];
      end
    end
    w_addr_m = w_addr;
    if (!io_addr4b || ADDR_W == 24) begin
      for (int b = 24; b < ADDR_W; b++) w_addr_m[b] = 1'b0;
    end
    w_asz = (ADDR_W == 32 && io_addr4b) ? 4'b0100 : 4'b0011;
  end

  // Ready is one-hot to the winner and only offered in IDLE (and out of reset).
  always_comb begin
    io_req_ready = '0;
    for (int k = 0; k < NUM_CH; k++)
      io_req_ready[k] = rst_n && (r_state == S_IDLE) && w_found && (w_gnt == 3'(k));
  end

  assign w_acc     = (r_state == S_IDLE) && w_found;
  assign w_illegal = w_flags[1] & w_flags[0];
  assign w_ptr_nxt = (w_gnt == 3'(NUM_CH-1)) ? 3'd0 : w_gnt + 3'd1;
  // Expiry on the TIMEOUT-th BUSY cycle; a simultaneous done takes priority.
  assign w_to      = (TIMEOUT > 0) && (r_state == S_BUSY) && !io_cmd_done &&
                     (r_cnt == 16'(TIMEOUT-1));

  // Main FSM: accept/latch in IDLE, handshake in ISSUE, wait for done in BUSY.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_ch    <= '0;
      r_inst  <= '0;
      r_addr  <= '0;
      r_flags <= '0;
      r_asz   <= '0;
      r_size  <= '0;
      r_bl    <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_acc) begin
          if (PRIO_MODE != 0) r_ptr <= w_ptr_nxt;
          if (w_illegal) begin
            // write+read together is meaningless: consume and flag, keep old command
            r_err <= 1'b1;
          end else begin
            r_ch    <= w_gnt;
            r_inst  <= w_inst;
            r_addr  <= w_addr_m;
            r_flags <= w_flags;
            r_asz   <= w_asz;
            r_size  <= w_size;
            r_bl    <= w_bl;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: if (io_cmd_ready) begin
          r_state <= S_BUSY;
          r_cnt   <= '0;
        end
        S_BUSY: begin
          if (io_cmd_done || w_to) r_state <= S_IDLE;
          else                     r_cnt   <= r_cnt + 16'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_cmd_valid     = (r_state == S_ISSUE);
  assign io_busy          = (r_state != S_IDLE);
  assign io_err           = r_err;
  assign io_timeout       = w_to;
  assign io_cmd_ch        = r_ch;
  assign io_inst          = r_inst;
  assign io_addr          = r_addr;
  assign {io_addr_valid, io_dummy_valid, io_wr_valid, io_rd_valid} = r_flags;
  assign io_addr_size     = r_asz;
  assign io_data_size     = r_size;
  assign io_data_burstlen = r_bl;
  // Fixed sizes still read as zero while reset is held, like every other output.
  assign io_inst_size     = rst_n ? 4'b0001 : 4'b0000;
  assign io_dummy_size    = rst_n ? 4'b0011 : 4'b0000;

endmodule
